// File: rtl/fifo_mem_pkg.sv
// Shared constants and sizing helper for the fifo_mem block.
// Optional feature macro: FIFO_MEM_STICKY_ERR_EN (see fifo_mem.sv).
package fifo_mem_pkg;

    localparam int FIFO_MEM_DATA_WIDTH_DEF = 16;
    localparam int FIFO_MEM_OSTD_NUM_DEF   = 18;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int fifo_mem_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fifo_mem_ram.sv
// 1-write / 1-async-read register array backing the FIFO; contents are never reset.
module fifo_mem_ram
    import fifo_mem_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_MEM_DATA_WIDTH_DEF,
    parameter int OSTD_NUM   = FIFO_MEM_OSTD_NUM_DEF,
    parameter int ADDR_W     = fifo_mem_width(OSTD_NUM)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [OSTD_NUM];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_mem.sv
// Single-clock FWFT FIFO with empty/full/threshold status and overflow/underflow flags.
// Define FIFO_MEM_STICKY_ERR_EN to make the error indicators sticky until reset.
module fifo_mem
    import fifo_mem_pkg::*;
#(
    parameter int DATA_WIDTH      = FIFO_MEM_DATA_WIDTH_DEF,
    parameter int OSTD_NUM        = FIFO_MEM_OSTD_NUM_DEF,
    parameter int THRESHOLD_VALUE = OSTD_NUM / 2
) (
    input  logic                  clk_in,
    input  logic                  areset_b,
    input  logic                  trans_write,
    input  logic                  trans_read,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full_ind,
    output logic                  empty_ind,
    output logic                  threshold_ind,
    output logic                  overflow_ind,
    output logic                  underflow_ind
);

    localparam int PTR_W = fifo_mem_width(OSTD_NUM);
    localparam int CNT_W = fifo_mem_width(OSTD_NUM + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OSTD_NUM - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OSTD_NUM);
    localparam logic [CNT_W-1:0] CNT_THR  = CNT_W'(THRESHOLD_VALUE);

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_ovf_evt;
    logic                  w_udf_evt;
    logic [PTR_W-1:0]      w_wr_ptr_nxt;
    logic [PTR_W-1:0]      w_rd_ptr_nxt;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);

    // A pop frees the slot this same edge, so a full FIFO can still take a write.
    assign w_rd_acc  = trans_read  && !w_empty;
    assign w_wr_acc  = trans_write && (!w_full || w_rd_acc);
    assign w_ovf_evt = trans_write && !w_wr_acc;
    assign w_udf_evt = trans_read  && !w_rd_acc;

    // Depth need not be a power of two, so wrap explicitly at the last index.
    assign w_wr_ptr_nxt = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;

    fifo_mem_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .OSTD_NUM   (OSTD_NUM),
        .ADDR_W     (PTR_W)
    ) u_ram (
        .clk     (clk_in),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk_in) begin
        if (areset_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (areset_b) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
`ifdef FIFO_MEM_STICKY_ERR_EN
            r_ovf <= r_ovf | w_ovf_evt;
            r_udf <= r_udf | w_udf_evt;
`else
            r_ovf <= w_ovf_evt;
            r_udf <= w_udf_evt;
`endif
        end
    end

    assign data_out      = w_empty ? '0 : w_rd_data;
    assign full_ind      = w_full;
    assign empty_ind     = w_empty;
    assign threshold_ind = (r_count >= CNT_THR);
    assign overflow_ind  = r_ovf;
    assign underflow_ind = r_udf;

endmodule

// File: tb/tb_fifo_mem.sv
// Scoreboard bench for fifo_mem at default parameters (16, 18, 9).
module tb_fifo_mem;

    localparam int DW  = 16;
    localparam int N   = 18;
    localparam int THR = N / 2;

    logic          clk_in = 1'b0;
    logic          areset_b = 1'b1;
    logic          trans_write = 1'b0;
    logic          trans_read = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          full_ind, empty_ind, threshold_ind, overflow_ind, underflow_ind;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] dcnt;

    fifo_mem dut (
        .clk_in        (clk_in),
        .areset_b      (areset_b),
        .trans_write   (trans_write),
        .trans_read    (trans_read),
        .data_in       (data_in),
        .data_out      (data_out),
        .full_ind      (full_ind),
        .empty_ind     (empty_ind),
        .threshold_ind (threshold_ind),
        .overflow_ind  (overflow_ind),
        .underflow_ind (underflow_ind)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_status();
        chk("empty", empty_ind, sb_q.size() == 0);
        chk("full", full_ind, sb_q.size() == N);
        chk("thr", threshold_ind, sb_q.size() >= THR);
        chk("dout", data_out, (sb_q.size() == 0) ? 32'h0 : 32'(sb_q[0]));
    endtask

    // One clock of traffic; called #1 after a rising edge.
    task automatic step(input bit wr, input bit rd, input logic [DW-1:0] d);
        bit rd_acc, wr_acc;
        rd_acc = rd && (sb_q.size() > 0);
        wr_acc = wr && ((sb_q.size() < N) || rd_acc);
        trans_write = wr;
        trans_read  = rd;
        data_in     = d;
        if (rd_acc) chk("rd_data", data_out, sb_q.pop_front());
        if (wr_acc) sb_q.push_back(d);
        @(posedge clk_in);
        #1;
        trans_write = 1'b0;
        trans_read  = 1'b0;
        chk("ovf", overflow_ind, wr && !wr_acc);
        chk("udf", underflow_ind, rd && !rd_acc);
        chk_status();
    endtask

    task automatic do_reset(input int cycles);
        areset_b = 1'b1;
        repeat (cycles) @(posedge clk_in);
        #1;
        areset_b = 1'b0;
        sb_q.delete();
        chk("rst_ovf", overflow_ind, 0);
        chk("rst_udf", underflow_ind, 0);
        chk_status();
    endtask

    initial begin
        do_reset(2);

        // fill, then one rejected write
        for (int i = 1; i <= N; i++) step(1, 0, DW'(i));
        step(1, 0, 16'hDEAD);
        step(0, 0, '0);

        // drain, then one rejected read
        for (int i = 0; i < N; i++) step(0, 1, '0);
        step(0, 1, '0);
        step(0, 0, '0);

        // pointer wrap at non-power-of-two depth
        dcnt = 16'h0100;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N - 1; i++) begin
                step(1, 0, dcnt);
                dcnt++;
            end
            for (int i = 0; i < N - 1; i++) step(0, 1, '0);
        end

        // simultaneous access while full
        for (int i = 0; i < N; i++) step(1, 0, 16'h0200 + DW'(i));
        for (int i = 0; i < 3; i++) step(1, 1, 16'h0300 + DW'(i));
        for (int i = 0; i < N; i++) step(0, 1, '0);

        // simultaneous access while empty
        step(1, 1, 16'h0BEE);
        step(0, 1, '0);

        // random mix
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom));

        // reset during traffic
        do_reset(1);
        for (int i = 0; i < 5; i++) step(1, 0, 16'h0050 + DW'(i));
        do_reset(1);
        step(1, 0, 16'h00AA);
        chk("post_rst_aa", data_out, 32'h00AA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_mem.md
# fifo_mem

Single-clock synchronous FIFO buffer with first-word-fall-through read data and status/error indicators (empty, full, threshold, overflow, underflow). Decouples a producer and a consumer that share `clk_in`, holding up to `OSTD_NUM` outstanding words of `DATA_WIDTH` bits.

## Interface
Parameters:
- `DATA_WIDTH`, 16: word width in bits.
- `OSTD_NUM`, 18: depth in words. Any value ≥ 2; need not be a power of two.
- `THRESHOLD_VALUE`, `OSTD_NUM/2`: fill level at which `threshold_ind` asserts. Range 1..`OSTD_NUM`.

Ports (one clock; reset is synchronous and active-high):
- `clk_in`, input, 1: clock. All state changes on the rising edge.
- `areset_b`, input, 1: synchronous, active-high reset. The name is kept for codebase consistency; it is not active-low or asynchronous.
- `trans_write`, input, 1: write request, sampled each rising edge.
- `trans_read`, input, 1: read/pop request, sampled each rising edge.
- `data_in`, input, `DATA_WIDTH`: write data, captured with `trans_write`.
- `data_out`, output, `DATA_WIDTH`: head-of-FIFO word.
- `full_ind`, output, 1: count == `OSTD_NUM`.
- `empty_ind`, output, 1: count == 0.
- `threshold_ind`, output, 1: count ≥ `THRESHOLD_VALUE`.
- `overflow_ind`, output, 1: a write was rejected.
- `underflow_ind`, output, 1: a read was rejected.

## Operation
- State: storage array `[OSTD_NUM]`, write pointer, read pointer, and occupancy count.
  - Pointers are $clog2(`OSTD_NUM`) bits and wrap from `OSTD_NUM-1` to 0. Wrap is explicit and is not power-of-two rollover.
  - Count is $clog2(`OSTD_NUM+1`) bits.
- Write accepted when `trans_write` and (not full, or a read is accepted in the same cycle).
  - Store `data_in` at the write pointer, then advance the write pointer.
- Read accepted when `trans_read` and not empty.
  - Advance the read pointer; popped data is not cleared.
- Count change: +1 on write only, −1 on read only, unchanged on both or neither.
- Simultaneous read and write:
  - When full: both are accepted and there is no overflow.
  - When empty: the write is accepted, the read is rejected, and underflow is flagged.
- `data_out` is the array entry at the read pointer (first-word fall-through), driven combinationally from registered state. It is forced to all zeros while `empty_ind` is 1.
- `full_ind`, `empty_ind` and `threshold_ind` are combinational decodes of the count register.
- `overflow_ind` asserts for a `trans_write` that is not accepted. `underflow_ind` asserts for a `trans_read` that is not accepted.
- Reset: pointers and count go to 0, and `overflow_ind`/`underflow_ind` go to 0.
  - Resulting outputs: `empty_ind`=1, `full_ind`=0, `threshold_ind`=0, `data_out`=0.
  - Array contents are not reset.
- Reset has priority over any request in the same cycle. Reset during traffic discards all stored data.

## Timing
- A write at edge N makes the word visible on `data_out` (if the FIFO was empty) and updates the flags after edge N. Fall-through latency is one cycle.
- A read at edge N presents the next word on `data_out` after edge N. The consumer samples `data_out` in the same cycle it asserts `trans_read`.
- `overflow_ind`/`underflow_ind` are registered. They are high for exactly the one cycle following the offending edge.
- There is no combinational path from `trans_*` or `data_in` to any output.

## Configuration
- `FIFO_MEM_STICKY_ERR_EN` defined: `overflow_ind` and `underflow_ind` are sticky. Each stays set after its first event until reset.
- `FIFO_MEM_STICKY_ERR_EN` undefined (default): each error indicator is a one-cycle pulse per rejected request.

## Structure
- Package `fifo_mem_pkg` holds:
  - Default constants (`FIFO_MEM_DATA_WIDTH_DEF`=16, `FIFO_MEM_OSTD_NUM_DEF`=18).
  - A width helper function for pointer and count sizing.
- One sub-module `fifo_mem_ram`: a 1-write/1-async-read register array parameterised by `DATA_WIDTH` and `OSTD_NUM`.
- Pointers, count, flags and the error logic stay in `fifo_mem`.

## Test plan
All scenarios use the default parameters (16, 18, 9).
- Reset check: assert `areset_b` for 2 cycles → `empty_ind`=1, `full_ind`=0, `threshold_ind`=0, `data_out`=0x0000, error indicators 0.
- Fill with 0x0001..0x0012 (18 writes) → `threshold_ind` rises after the 9th write, `full_ind` after the 18th. A 19th write → `overflow_ind` pulses one cycle, and `data_out` still reads 0x0001.
- Drain 18 reads, checking `data_out` in each read cycle → sequence 0x0001..0x0012, then `empty_ind`=1. A 19th read → `underflow_ind` pulses and the count stays 0.
- Wrap-around: write 17 and read 17, repeated 3 times with incrementing data → order preserved across the pointer wrap at index 17→0.
- Simultaneous read and write:
  - When full: count stays 18, `data_out` advances, no overflow.
  - When empty: the word is stored, `empty_ind` drops next cycle, `underflow_ind` pulses.
- Mid-operation reset after 5 writes → all flags return to reset values, and the next write of 0x00AA appears on `data_out`.
